snapshot_bram_reader: RTL and testbench
=======================================

// Module: snapshot_bram_reader
// PURPOSE
//  Playback engine for the 128-bit snapshot BRAMs. Reads port A of a CPU-loaded block (the CPU writes it over the 32-bit port B).
//  Streams len words out as a valid/ready beat stream, e.g. to feed the 10GbE TX path.
//  Absorbs the 1-cycle BRAM read latency with a 2-entry skid buffer, so full throughput holds under backpressure.
// PARAMETERS
//  DATA_W  128  BRAM port A / stream data width
//  ADDR_W  12   port A word address width; max length = 2**ADDR_W words
// PORTS
//  clk           in   1         sole clock; BRAM port A clock
//  rst_n         in   1         synchronous reset, active low
//  start         in   1         1-cycle pulse: begin playback from address 0
//  stop          in   1         1-cycle pulse: abort playback
//  len           in   ADDR_W+1  words per pass, sampled on accepted start
//  loop_en       in   1         sampled on accepted start; 1 = repeat passes until stop
//  bram_en_a     out  1         port A read enable
//  bram_addr     out  ADDR_W    port A word address
//  bram_rd_data  in   DATA_W    port A read data, valid 1 cycle after bram_en_a
//  out_data      out  DATA_W    stream data
//  out_valid     out  1         stream valid
//  out_ready     in   1         stream ready; beat transfers when valid & ready
//  out_last      out  1         marks the final word of each pass
//  busy          out  1         high from accepted start until return to IDLE
//  done          out  1         1-cycle pulse after the final beat of a non-loop run
//  cksum         out  32        running checksum (feature-gated, see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): every output 0, skid buffer emptied, FSM to IDLE. Applies mid-run too; no done pulse.
//  - FSM states and transitions:
//    IDLE -> RUN on start with len!=0.
//    RUN -> DRAIN once read len-1 has issued and loop_en=0.
//    DRAIN -> IDLE when the last beat transfers; done pulses the following cycle.
//  - start ignored while busy=1. start with len=0: done pulses next cycle, no beats, busy stays 0.
//  - len > 2**ADDR_W is clamped to 2**ADDR_W.
//  - Reads: bram_en_a=1 only when (reads in flight + buffered words) < 2.
//    bram_addr increments by 1 per issued read. At most 1 read issued per cycle.
//  - Latency: start at cycle 0 -> bram_en_a at cycle 1 -> out_valid at cycle 2, addr 0 data.
//  - With out_ready held high: 1 beat per cycle, no bubbles.
//  - out_valid holds once asserted: out_data/out_last stay stable until transfer (AXI-stream rule). Beats are never lost or duplicated.
//  - Buffer full: reads stall. When out_ready rises, data flows again the next cycle.
//  - out_last=1 on the beat read from address len-1.
//  - Loop mode: after address len-1, bram_addr wraps to 0 with no gap cycle. out_last marks each pass; done never pulses; only stop ends the run.
//  - stop in RUN/DRAIN: no further reads; buffered and in-flight words discarded.
//    out_valid=0 the next cycle; FSM to IDLE, busy=0 the next cycle; no done pulse.
//  - start and stop in the same cycle while IDLE: stop wins, nothing starts.
//  - Address counter: ADDR_W bits, wraps modulo 2**ADDR_W. Beat counter: ADDR_W+1 bits, compared against the clamped len.
// CONFIGURATION
//  - SNAPSHOT_READER_CKSUM_EN defined:
//    cksum = mod-2**32 sum of the four 32-bit lanes of every transferred beat.
//    Cleared to 0 on accepted start; holds after the run ends; cleared by reset.
//    Counts beats only (valid & ready), never discarded words.
//  - SNAPSHOT_READER_CKSUM_EN undefined: cksum tied to 0; no adder logic built.
// TESTING
//  1. len=4, loop_en=0, ready=1, BRAM[i]=i -> beats 0,1,2,3 on cycles 2..5; last on beat 3; done at cycle 6; busy 1..6.
//  2. len=8, ready toggling 1,0,0,1,... -> 8 beats in order; data stable while stalled; bram_en_a never has >2 words outstanding.
//  3. len=3, loop_en=1, ready=1 -> data 0,1,2,0,1,2,... with last every 3rd beat; stop after 7 beats -> valid=0 next cycle, no done.
//  4. len=0 start -> single done pulse next cycle, no out_valid. len=4097 -> exactly 4096 beats.
//  5. start while busy ignored; start+stop together in IDLE -> busy stays 0; rst_n=0 mid-run -> all outputs 0 next cycle.
//  6. CKSUM_EN set, len=2, words {1,2,3,4} and {5,6,7,8} -> cksum=36 after run; undefined -> cksum=0 throughout.

Source files
------------

// File: rtl/snapshot_bram_reader.sv
// snapshot_bram_reader
// Playback engine for a CPU-loaded snapshot BRAM. Reads port A and streams
// len words as a valid/ready beat stream, once or looping until stopped.
// A 2-entry skid buffer absorbs the 1-cycle BRAM read latency, so the stream
// sustains one beat per cycle and never drops a word under backpressure.
// Optional feature: define SNAPSHOT_READER_CKSUM_EN to build the running
// checksum; otherwise cksum is tied to 0.
module snapshot_bram_reader #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W:0]   len,
    input  logic              loop_en,
    output logic              bram_en_a,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [31:0]       cksum
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [ADDR_W:0]     rd_cnt_q;
    logic [ADDR_W:0]     len_q;
    logic                loop_q;
    logic                inflight_q;
    logic                inflight_last_q;
    logic [DATA_W-1:0]   buf_data_q [2];
    logic                buf_last_q [2];
    logic                buf_rd_ptr_q;
    logic                buf_wr_ptr_q;
    logic [1:0]          buf_cnt_q;
    logic                busy_q;
    logic                done_q;

    logic [ADDR_W:0]     len_clamped;
    logic                accept;
    logic [1:0]          occupancy;
    logic                issue;
    logic                issue_last;
    logic                buf_empty;
    logic                beat;
    logic                push;
    logic                pop;
    logic                done_d;

    assign busy = busy_q;
    assign done = done_q;

    // Next-state logic, read issue and stream output selection.
    always_comb begin
        // NOTE: every signal gets its default before any branch, so no path can infer a latch.
        state_d     = state_q;
        len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
        accept      = (state_q == IDLE) && !busy_q && start && !stop;
        done_d      = accept && (len_clamped == '0);
        occupancy   = buf_cnt_q + {1'b0, inflight_q};
        issue       = (state_q == RUN) && !stop && (occupancy < 2'd2);
        issue_last  = (rd_cnt_q == len_q - CNT_ONE);
        buf_empty   = (buf_cnt_q == 2'd0);
        bram_en_a   = issue;
        bram_addr   = rd_addr_q;

        // Oldest word is the buffer head; with an empty buffer the BRAM
        // output passes straight through, which removes a cycle of latency.
        out_valid = !buf_empty || inflight_q;
        out_data  = '0;
        out_last  = 1'b0;
        if (!buf_empty) begin
            out_data = buf_data_q[buf_rd_ptr_q];
            out_last = buf_last_q[buf_rd_ptr_q];
        end else if (inflight_q) begin
            out_data = bram_rd_data;
            out_last = inflight_last_q;
        end

        beat = out_valid && out_ready;
        push = inflight_q && !(buf_empty && out_ready);
        pop  = beat && !buf_empty;

        case (state_q)
            IDLE: begin
                if (accept && (len_clamped != '0)) state_d = RUN;
            end
            RUN: begin
                if (stop)                                    state_d = IDLE;
                else if (issue && issue_last && !loop_q)     state_d = DRAIN;
            end
            DRAIN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (beat && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Read counters, in-flight tracking, skid-buffer occupancy and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr_q       <= '0;
            rd_cnt_q        <= '0;
            len_q           <= '0;
            loop_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_rd_ptr_q    <= 1'b0;
            buf_wr_ptr_q    <= 1'b0;
            buf_cnt_q       <= 2'd0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            if (accept) begin
                rd_addr_q <= '0;
                rd_cnt_q  <= '0;
                len_q     <= len_clamped;
                loop_q    <= loop_en;
            end else if (issue) begin
                rd_addr_q <= (issue_last && loop_q) ? '0 : rd_addr_q + ADDR_ONE;
                rd_cnt_q  <= issue_last ? '0 : rd_cnt_q + CNT_ONE;
            end

            // A stop blocks issue, so the in-flight word is dropped here too.
            inflight_q      <= issue;
            inflight_last_q <= issue && issue_last;

            if (stop) begin
                buf_rd_ptr_q <= 1'b0;
                buf_wr_ptr_q <= 1'b0;
                buf_cnt_q    <= 2'd0;
            end else begin
                if (push) buf_wr_ptr_q <= ~buf_wr_ptr_q;
                if (pop)  buf_rd_ptr_q <= ~buf_rd_ptr_q;
                case ({push, pop})
                    2'b10:   buf_cnt_q <= buf_cnt_q + 2'd1;
                    2'b01:   buf_cnt_q <= buf_cnt_q - 2'd1;
                    default: buf_cnt_q <= buf_cnt_q;
                endcase
            end

            // busy spans the done cycle so a start there is still ignored.
            if (accept && (len_clamped != '0)) busy_q <= 1'b1;
            else if (stop || done_q)           busy_q <= 1'b0;

            done_q <= done_d;
        end
    end

    // Skid-buffer storage; the occupancy count alone says which entries are live.
    always_ff @(posedge clk) begin
        // NOTE: data storage is deliberately not reset; emptying the buffer only needs the count cleared.
        if (push) begin
            buf_data_q[buf_wr_ptr_q] <= bram_rd_data;
            buf_last_q[buf_wr_ptr_q] <= inflight_last_q;
        end
    end

`ifdef SNAPSHOT_READER_CKSUM_EN
    localparam int LANES = DATA_W / 32;

    logic [31:0] lane_sum;
    logic [31:0] cksum_q;

    // Sum of the 32-bit lanes of the word currently presented.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + out_data[i*32 +: 32];
        end
    end

    // Running checksum over transferred beats only.
    always_ff @(posedge clk) begin
        if (!rst_n)      cksum_q <= '0;
        else if (accept) cksum_q <= '0;
        else if (beat)   cksum_q <= cksum_q + lane_sum;
    end

    assign cksum = cksum_q;
`else
    assign cksum = '0;
`endif

endmodule

// File: tb/tb_snapshot_bram_reader.sv
// Self-checking bench for snapshot_bram_reader: directed scenarios against a
// behavioural BRAM with 1-cycle read latency. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_snapshot_bram_reader;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              loop_en = 1'b0;
    logic              bram_en_a;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_rd_data = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [31:0]       cksum;

    logic [DATA_W-1:0] mem [4096];

    int errors = 0;
    int checks = 0;

    snapshot_bram_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .len          (len),
        .loop_en      (loop_en),
        .bram_en_a    (bram_en_a),
        .bram_addr    (bram_addr),
        .bram_rd_data (bram_rd_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .cksum        (cksum)
    );

    always #5 clk = ~clk;

    // Port A model: registered read, data valid one cycle after the enable.
    always @(posedge clk) begin
        if (bram_en_a) bram_rd_data <= mem[bram_addr];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({busy, out_valid, out_last, done, bram_en_a} !== 5'b0)
            begin errors++; $display("FAIL reset_ctl: got %b want 00000", {busy, out_valid, out_last, done, bram_en_a}); end
        checks++;
        if (out_data !== '0 || bram_addr !== '0 || cksum !== 32'd0)
            begin errors++; $display("FAIL reset_data: data=%0h addr=%0d cksum=%0d want 0", out_data, bram_addr, cksum); end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    // len=4, ready high: exact cycle timing of reads, beats, last, busy and done.
    task automatic test_basic();
        logic [4:0] exp_ctl;
        len = 13'd4; loop_en = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            start = (c == 0);
            @(negedge clk);
            exp_ctl = {(c >= 1 && c <= 6), (c >= 2 && c <= 5), (c == 5), (c == 6), (c >= 1 && c <= 4)};
            checks++;
            if ({busy, out_valid, out_last, done, bram_en_a} !== exp_ctl)
                begin errors++; $display("FAIL basic_ctl c=%0d: got %b want %b", c, {busy, out_valid, out_last, done, bram_en_a}, exp_ctl); end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (out_data !== DATA_W'(c - 2))
                    begin errors++; $display("FAIL basic_data c=%0d: got %0h want %0h", c, out_data, c - 2); end
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (bram_addr !== ADDR_W'(c - 1))
                    begin errors++; $display("FAIL basic_addr c=%0d: got %0d want %0d", c, bram_addr, c - 1); end
            end
            next_cycle();
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
`ifdef SNAPSHOT_READER_CKSUM_EN
        if (cksum !== 32'd6) begin errors++; $display("FAIL basic_cksum: got %0d want 6", cksum); end
`else
        if (cksum !== 32'd0) begin errors++; $display("FAIL basic_cksum: got %0d want 0", cksum); end
`endif
        next_cycle();
    endtask

    // len=8 with ready pattern 1,0,0,1: ordering, stability and read pacing.
    task automatic test_backpressure();
        int beats = 0;
        int outstanding = 0;
        bit prev_stall = 0;
        bit seen_done = 0;
        logic [DATA_W-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        len = 13'd8; loop_en = 1'b0;
        for (int c = 0; c < 80 && !seen_done; c++) begin
            start = (c == 0);
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            @(negedge clk);
            if (bram_en_a) begin
                checks++;
                if (outstanding >= 2)
                    begin errors++; $display("FAIL bp_pacing c=%0d: outstanding=%0d want <2 at read", c, outstanding); end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last)
                    begin errors++; $display("FAIL bp_stable c=%0d: valid=%b data=%0h want 1 %0h", c, out_valid, out_data, prev_data); end
            end
            outstanding = outstanding + int'(bram_en_a) - int'(out_valid && out_ready);
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== DATA_W'(beats) || out_last !== (beats == 7))
                    begin errors++; $display("FAIL bp_beat %0d: data=%0h last=%b want %0h %b", beats, out_data, out_last, beats, beats == 7); end
                beats++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) seen_done = 1;
            next_cycle();
        end
        start = 1'b0; out_ready = 1'b1;
        checks++;
        if (beats != 8 || !seen_done)
            begin errors++; $display("FAIL bp_total: beats=%0d done=%0d want 8 1", beats, seen_done); end
        next_cycle();
    endtask

    // len=3 loop mode; stop after 7 beats.
    task automatic test_loop();
        int beats = 0;
        int stop_cyc = -1;
        len = 13'd3; loop_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            start = (c == 0);
            stop = (beats == 7) && (stop_cyc < 0);
            if (stop) stop_cyc = c;
            out_ready = !stop;
            @(negedge clk);
            if (stop_cyc >= 0 && c > stop_cyc) begin
                checks++;
                if ({out_valid, busy, done, bram_en_a} !== 4'b0)
                    begin errors++; $display("FAIL loop_after_stop c=%0d: got %b want 0000", c, {out_valid, busy, done, bram_en_a}); end
            end else if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || done !== 1'b0)
                    begin errors++; $display("FAIL loop_flow c=%0d: valid=%b done=%b want 1 0", c, out_valid, done); end
                if (out_valid && out_ready) begin
                    checks++;
                    if (out_data !== DATA_W'(beats % 3) || out_last !== ((beats % 3) == 2))
                        begin errors++; $display("FAIL loop_beat %0d: data=%0h last=%b want %0h %b", beats, out_data, out_last, beats % 3, (beats % 3) == 2); end
                    beats++;
                end
            end
            next_cycle();
        end
        stop = 1'b0; loop_en = 1'b0; out_ready = 1'b1;
        checks++;
        if (stop_cyc != 9)
            begin errors++; $display("FAIL loop_stop_cycle: got %0d want 9", stop_cyc); end
    endtask

    // len=0 gives a bare done pulse; len=4097 clamps to 4096 beats.
    task automatic test_len_bounds();
        int beats = 0;
        bit seen_done = 0;
        len = 13'd0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            start = (c == 0);
            @(negedge clk);
            checks++;
            if ({busy, out_valid, done, bram_en_a} !== {3'b000 | {2'b00, c == 1}, 1'b0})
                begin errors++; $display("FAIL len0 c=%0d: got %b want 00%b0", c, {busy, out_valid, done, bram_en_a}, c == 1); end
            next_cycle();
        end
        len = 13'd4097;
        for (int c = 0; c < 4200 && !seen_done; c++) begin
            start = (c == 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== DATA_W'(beats) || out_last !== (beats == 4095))
                    begin errors++; $display("FAIL clamp_beat %0d: data=%0h last=%b", beats, out_data, out_last); end
                beats++;
            end
            if (done) seen_done = 1;
            next_cycle();
        end
        start = 1'b0;
        checks++;
        if (beats != 4096 || !seen_done)
            begin errors++; $display("FAIL clamp_total: beats=%0d done=%0d want 4096 1", beats, seen_done); end
    endtask

    // start while busy, start+stop in IDLE, reset mid-run.
    task automatic test_control();
        int beats = 0;
        int dones = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            start = (c == 0) || (c == 2) || (c == 6);
            len = (c == 0) ? 13'd4 : 13'd2;
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (out_data !== DATA_W'(beats))
                    begin errors++; $display("FAIL busy_start_beat %0d: got %0h want %0h", beats, out_data, beats); end
                beats++;
            end
            if (done) dones++;
            next_cycle();
        end
        start = 1'b0;
        checks++;
        if (beats != 4 || dones != 1)
            begin errors++; $display("FAIL busy_start_total: beats=%0d dones=%0d want 4 1", beats, dones); end

        len = 13'd4; start = 1'b1; stop = 1'b1;
        next_cycle();
        start = 1'b0; stop = 1'b0;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, out_valid, bram_en_a, done} !== 4'b0)
                begin errors++; $display("FAIL start_stop c=%0d: got %b want 0000", c, {busy, out_valid, bram_en_a, done}); end
            next_cycle();
        end

        len = 13'd8;
        for (int c = 0; c < 10; c++) begin
            start = (c == 0);
            rst_n = !(c == 4);
            @(negedge clk);
            if (c == 5) begin
                checks++;
                if ({busy, out_valid, out_last, done, bram_en_a} !== 5'b0 || out_data !== '0 || bram_addr !== '0 || cksum !== 32'd0)
                    begin errors++; $display("FAIL midrun_reset: ctl=%b data=%0h addr=%0d cksum=%0d want 0", {busy, out_valid, out_last, done, bram_en_a}, out_data, bram_addr, cksum); end
            end else if (c > 5) begin
                checks++;
                if ({out_valid, done, busy} !== 3'b0)
                    begin errors++; $display("FAIL midrun_after c=%0d: got %b want 000", c, {out_valid, done, busy}); end
            end
            next_cycle();
        end
        start = 1'b0; rst_n = 1'b1;
    endtask

    // len=2 over words {1,2,3,4} and {5,6,7,8}.
    task automatic test_cksum();
        logic [31:0] want;
        bit seen_done = 0;
`ifdef SNAPSHOT_READER_CKSUM_EN
        want = 32'd36;
`else
        want = 32'd0;
`endif
        mem[0] = {32'd4, 32'd3, 32'd2, 32'd1};
        mem[1] = {32'd8, 32'd7, 32'd6, 32'd5};
        len = 13'd2; out_ready = 1'b1;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            start = (c == 0);
            @(negedge clk);
            if (done) seen_done = 1;
            next_cycle();
        end
        start = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (cksum !== want || !seen_done)
            begin errors++; $display("FAIL cksum: got %0d done=%0d want %0d 1", cksum, seen_done, want); end
        next_cycle();
        mem[0] = DATA_W'(0);
        mem[1] = DATA_W'(1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = DATA_W'(i);
        next_cycle();
        test_reset();
        test_basic();
        test_backpressure();
        test_loop();
        test_len_bounds();
        test_control();
        test_cksum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
